// File: rtl/cu_power_sequencer.sv
// Power sequencer for NUM_CHANNELS compute units plus the shared L2: per-channel wake/reset/drain
// FSMs and an L2 FSM with dependent power-up and an idle cool-down before gating.
module cu_power_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int RST_CYCLES     = 2,
  parameter int DRAIN_CYCLES   = 4,
  parameter int L2_IDLE_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CHANNELS-1:0] start_i,
  input  logic [NUM_CHANNELS-1:0] sleep_req_i,
  input  logic [NUM_CHANNELS-1:0] delay_sleep_i,
  input  logic                    l2_busy_i,
  output logic [NUM_CHANNELS-1:0] cu_clk_en_o,
  output logic [NUM_CHANNELS-1:0] cu_rst_n_o,
  output logic [NUM_CHANNELS-1:0] cu_active_o,
  output logic                    l2_clk_en_o,
  output logic                    l2_rst_n_o,
  output logic                    all_off_o
);

  localparam int CH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CW     = $clog2(CH_MAX) + 1;
  localparam int L2_MAX = (RST_CYCLES > L2_IDLE_CYCLES) ? RST_CYCLES : L2_IDLE_CYCLES;
  localparam int LW     = $clog2(L2_MAX) + 1;

  localparam logic [CW-1:0] CH_RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CH_DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [LW-1:0] L2_RST_LAST   = LW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] L2_IDLE_LAST  = LW'(L2_IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    CH_OFF, CH_WAIT_L2, CH_RESET, CH_RUN, CH_DRAIN
  } ch_state_t;

  typedef enum logic [1:0] {
    L2_OFF, L2_RESET, L2_ON, L2_COOL
  } l2_state_t;

  // Counters saturate rather than wrap so a stalled count can never alias a terminal value.
  function automatic logic [CW-1:0] ch_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  function automatic logic [LW-1:0] l2_inc(input logic [LW-1:0] v);
    return (v == '1) ? v : v + LW'(1);
  endfunction

  l2_state_t               l2_state;
  logic [LW-1:0]           l2_cnt;
  logic                    l2_on;
  logic [NUM_CHANNELS-1:0] ch_off;
  logic [NUM_CHANNELS-1:0] ch_wait;

  assign l2_on = (l2_state == L2_ON);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    ch_state_t     state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state <= CH_OFF;
        cnt   <= '0;
      end else begin
        case (state)
          CH_OFF: begin
            if (start_i[g]) begin
              state <= l2_on ? CH_RESET : CH_WAIT_L2;
              cnt   <= '0;
            end
          end
          CH_WAIT_L2: begin
            if (l2_on) begin
              state <= CH_RESET;
              cnt   <= '0;
            end
          end
          CH_RESET: begin
            if (cnt == CH_RST_LAST) state <= CH_RUN;
            else                    cnt   <= ch_inc(cnt);
          end
          CH_RUN: begin
            if (sleep_req_i[g]) begin
              state <= CH_DRAIN;
              cnt   <= '0;
            end
          end
          CH_DRAIN: begin
            // A wake request cancels the drain even on the cycle it would have completed.
            if (start_i[g])                  state <= CH_RUN;
            else if (delay_sleep_i[g])       cnt   <= '0;
            else if (cnt == CH_DRAIN_LAST)   state <= CH_OFF;
            else                             cnt   <= ch_inc(cnt);
          end
          default: begin
            state <= CH_OFF;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign ch_off[g]      = (state == CH_OFF);
    assign ch_wait[g]     = (state == CH_WAIT_L2);
    assign cu_clk_en_o[g] = (state == CH_RESET) || (state == CH_RUN) || (state == CH_DRAIN);
    assign cu_rst_n_o[g]  = (state == CH_RUN) || (state == CH_DRAIN);
    assign cu_active_o[g] = (state == CH_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l2_state <= L2_OFF;
      l2_cnt   <= '0;
    end else begin
      case (l2_state)
        L2_OFF: begin
          if (|ch_wait) begin
            l2_state <= L2_RESET;
            l2_cnt   <= '0;
          end
        end
        L2_RESET: begin
          if (l2_cnt == L2_RST_LAST) l2_state <= L2_ON;
          else                       l2_cnt   <= l2_inc(l2_cnt);
        end
        L2_ON: begin
          if (&ch_off && !l2_busy_i) begin
            l2_state <= L2_COOL;
            l2_cnt   <= '0;
          end
        end
        L2_COOL: begin
          if (!(&ch_off) || l2_busy_i)   l2_state <= L2_ON;
          else if (l2_cnt == L2_IDLE_LAST) l2_state <= L2_OFF;
          else                           l2_cnt   <= l2_inc(l2_cnt);
        end
        default: begin
          l2_state <= L2_OFF;
          l2_cnt   <= '0;
        end
      endcase
    end
  end

  assign l2_clk_en_o = (l2_state != L2_OFF);
  assign l2_rst_n_o  = (l2_state == L2_ON) || (l2_state == L2_COOL);
  assign all_off_o   = (&ch_off) && (l2_state == L2_OFF);

endmodule

// File: tb/tb_cu_power_sequencer.sv
// Bench for cu_power_sequencer: directed timing steps from the test plan followed by random
// traffic, every cycle compared against a countdown/quiet-count reference model.
module tb_cu_power_sequencer;
  localparam int NCH = 4;
  localparam int RST = 2;
  localparam int DRN = 4;
  localparam int IDL = 8;
  localparam int VW  = 3 * NCH + 3;

  localparam int IDLE = 0, WAITING = 1, BOOTING = 2, RUNNING = 3, DRAINING = 4;
  localparam int DOWN = 0, WARMING = 1, UP = 2, COOLING = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] sleep = '0;
  logic [NCH-1:0] delay = '0;
  logic           busy = 1'b0;
  logic [NCH-1:0] cu_clk_en, cu_rst_n, cu_active;
  logic           l2_clk_en, l2_rst_n, all_off;
  logic [VW-1:0]  obs;

  cu_power_sequencer #(
    .NUM_CHANNELS(NCH), .RST_CYCLES(RST), .DRAIN_CYCLES(DRN), .L2_IDLE_CYCLES(IDL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sleep_req_i(sleep), .delay_sleep_i(delay),
    .l2_busy_i(busy), .cu_clk_en_o(cu_clk_en), .cu_rst_n_o(cu_rst_n), .cu_active_o(cu_active),
    .l2_clk_en_o(l2_clk_en), .l2_rst_n_o(l2_rst_n), .all_off_o(all_off)
  );

  always #5 clk = ~clk;

  assign obs = {cu_clk_en, cu_rst_n, cu_active, l2_clk_en, l2_rst_n, all_off};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase per channel, remaining boot cycles, consecutive quiet cycles.
  int ch[NCH];
  int left[NCH];
  int quiet[NCH];
  int l2 = DOWN;
  int l2left = 0;
  int l2idle = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NCH-1:0] ce, rn, ac;
    bit all_idle;
    all_idle = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ce[i] = (ch[i] == BOOTING) || (ch[i] == RUNNING) || (ch[i] == DRAINING);
      rn[i] = (ch[i] == RUNNING) || (ch[i] == DRAINING);
      ac[i] = (ch[i] == RUNNING);
      if (ch[i] != IDLE) all_idle = 1'b0;
    end
    return {ce, rn, ac, l2 != DOWN, (l2 == UP) || (l2 == COOLING), all_idle && (l2 == DOWN)};
  endfunction

  task automatic model_step();
    int  nch[NCH];
    int  nleft[NCH];
    int  nquiet[NCH];
    bit  all_idle;
    bit  any_wait;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ch[i] = IDLE; left[i] = 0; quiet[i] = 0;
      end
      l2 = DOWN; l2left = 0; l2idle = 0;
      return;
    end
    all_idle = 1'b1;
    any_wait = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch[i] != IDLE) all_idle = 1'b0;
      if (ch[i] == WAITING) any_wait = 1'b1;
      nch[i] = ch[i]; nleft[i] = left[i]; nquiet[i] = quiet[i];
      case (ch[i])
        IDLE:
          if (start[i]) begin
            if (l2 == UP) begin nch[i] = BOOTING; nleft[i] = RST; end
            else nch[i] = WAITING;
          end
        WAITING:
          if (l2 == UP) begin nch[i] = BOOTING; nleft[i] = RST; end
        BOOTING: begin
          nleft[i] = left[i] - 1;
          if (nleft[i] == 0) nch[i] = RUNNING;
        end
        RUNNING:
          if (sleep[i]) begin nch[i] = DRAINING; nquiet[i] = 0; end
        DRAINING:
          if (start[i]) nch[i] = RUNNING;
          else if (delay[i]) nquiet[i] = 0;
          else begin
            nquiet[i] = quiet[i] + 1;
            if (nquiet[i] == DRN) nch[i] = IDLE;
          end
        default: ;
      endcase
    end
    case (l2)
      DOWN:
        if (any_wait) begin l2 = WARMING; l2left = RST; end
      WARMING: begin
        l2left--;
        if (l2left == 0) l2 = UP;
      end
      UP:
        if (all_idle && !busy) begin l2 = COOLING; l2idle = 0; end
      COOLING:
        if (!all_idle || busy) l2 = UP;
        else begin
          l2idle++;
          if (l2idle == IDL) l2 = DOWN;
        end
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      ch[i] = nch[i]; left[i] = nleft[i]; quiet[i] = nquiet[i];
    end
  endtask

  task automatic tick();
    logic [VW-1:0] e;
    model_step();
    e = model_vec();
    @(posedge clk);
    #1;
    chk("model", 32'(obs), 32'(e));
  endtask

  int n;

  initial begin
    for (int i = 0; i < NCH; i++) begin ch[i] = IDLE; left[i] = 0; quiet[i] = 0; end

    rst = 1'b1;
    tick(); tick();
    chk("reset_all_off", 32'(all_off), 32'(1));
    chk("reset_outputs", 32'(obs[VW-1:1]), 32'(0));
    rst = 1'b0;
    tick();

    // Cold start on channel 0
    start = 4'b0001; tick(); start = '0;
    chk("cold_l2_en_t1", 32'(l2_clk_en), 32'(0));
    tick();
    chk("cold_l2_en_t2", 32'(l2_clk_en), 32'(1));
    chk("cold_l2_rst_t2", 32'(l2_rst_n), 32'(0));
    tick();
    chk("cold_l2_rst_t3", 32'(l2_rst_n), 32'(0));
    tick();
    chk("cold_l2_rst_t4", 32'(l2_rst_n), 32'(1));
    chk("cold_cu_en_t4", 32'(cu_clk_en), 32'(0));
    tick();
    chk("cold_cu_en_t5", 32'(cu_clk_en), 32'(4'b0001));
    chk("cold_cu_rst_t5", 32'(cu_rst_n), 32'(0));
    tick(); tick();
    chk("cold_cu_rst_t7", 32'(cu_rst_n), 32'(4'b0001));
    chk("cold_active_t7", 32'(cu_active), 32'(4'b0001));

    // Cancel on the cycle the drain would complete
    sleep = 4'b0001; tick(); sleep = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cancel_clk_held", 32'(cu_clk_en[0]), 32'(1));
    end
    start = 4'b0001; tick(); start = '0;
    chk("cancel_active", 32'(cu_active), 32'(4'b0001));
    chk("cancel_clk", 32'(cu_clk_en[0]), 32'(1));
    tick();
    chk("cancel_stays_run", 32'(cu_active[0]), 32'(1));

    // Drain restarted by outstanding traffic
    sleep = 4'b0001; tick(); sleep = '0;
    tick();
    delay = 4'b0001; tick(); tick(); delay = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_restart", 32'(cu_clk_en[0]), 32'(i < 4));
    end

    // L2 cool-down
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("l2_cool", 32'(l2_clk_en), 32'(i < 9));
    end
    chk("l2_cool_all_off", 32'(all_off), 32'(1));

    // Cool-down restarted by host traffic
    start = 4'b0001; tick(); start = '0;
    n = 0;
    while (cu_active[0] !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rewake_bound", 32'(cu_active[0]), 32'(1));
    sleep = 4'b0001; tick(); sleep = '0;
    n = 0;
    while (cu_clk_en[0] !== 1'b0 && n < 20) begin tick(); n++; end
    chk("redrain_bound", 32'(cu_clk_en[0]), 32'(0));
    tick();
    repeat (4) tick();
    busy = 1'b1; tick(); busy = 1'b0;
    chk("busy_l2_on", 32'(l2_clk_en), 32'(1));
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("l2_cool_busy", 32'(l2_clk_en), 32'(i < 9));
    end

    // Two channels from cold
    start = 4'b1010; tick(); start = '0;
    n = 0;
    while (cu_clk_en === '0 && n < 20) begin tick(); n++; end
    chk("multi_reset_together", 32'(cu_clk_en), 32'(4'b1010));
    chk("multi_reset_rst_n", 32'(cu_rst_n), 32'(0));
    repeat (RST) tick();
    chk("multi_run", 32'(cu_active), 32'(4'b1010));
    sleep = 4'b0010; tick(); sleep = '0;
    repeat (6) tick();
    chk("multi_ch1_off", 32'(cu_active), 32'(4'b1000));
    chk("multi_l2_on", 32'(l2_clk_en), 32'(1));
    chk("multi_not_all_off", 32'(all_off), 32'(0));

    // Reset during channel RESET
    start = 4'b0001; tick(); start = '0;
    chk("midreset_in_reset", 32'({cu_clk_en[0], cu_rst_n[0]}), 32'(2'b10));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midreset_outputs", 32'(obs[VW-1:1]), 32'(0));
    chk("midreset_all_off", 32'(all_off), 32'(1));

    // Reset during DRAIN
    start = 4'b0100; tick(); start = '0;
    n = 0;
    while (cu_active[2] !== 1'b1 && n < 20) begin tick(); n++; end
    chk("middrain_wake", 32'(cu_active[2]), 32'(1));
    sleep = 4'b0100; tick(); sleep = '0;
    tick();
    chk("middrain_in_drain", 32'({cu_clk_en[2], cu_active[2]}), 32'(2'b10));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("middrain_outputs", 32'(obs[VW-1:1]), 32'(0));
    chk("middrain_all_off", 32'(all_off), 32'(1));

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(7) == 0);
        sleep[i] = ($urandom_range(5) == 0);
        delay[i] = ($urandom_range(2) == 0);
      end
      busy = ($urandom_range(3) == 0);
      rst  = ($urandom_range(99) == 0);
      tick();
    end
    rst = 1'b0; start = '0; sleep = '0; delay = '0; busy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cu_power_sequencer.md
Name: cu_power_sequencer

Overview:
Parametrised power sequencer for N compute-unit channels plus the shared L2. It replaces the fixed sleep/clock-enable logic with per-channel FSMs that provide:
- a reset pulse on wake, with a programmable length;
- a drain window that is restarted by outstanding-traffic indication;
- a cancellable drain;
- dependent L2 power-up;
- an L2 cool-down timer.

It sits beside the configuration controller and drives the per-CU and L2 clock-gating cells and the resets.

Parameters:
NUM_CHANNELS, 4, number of compute-unit channels (>=1)
RST_CYCLES, 2, cycles reset is held low while clock is enabled on wake (>=1)
DRAIN_CYCLES, 4, consecutive quiet cycles required before gating a channel (>=1)
L2_IDLE_CYCLES, 8, consecutive idle cycles before gating L2 (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  NUM_CHANNELS  per-channel wake request (level or pulse)
sleep_req_i  in  NUM_CHANNELS  per-channel sleep request from CU
delay_sleep_i  in  NUM_CHANNELS  per-channel outstanding L2 traffic (blocks gating)
l2_busy_i  in  1  L2 has pending host transactions
cu_clk_en_o  out  NUM_CHANNELS  CU clock-gate enable
cu_rst_n_o  out  NUM_CHANNELS  CU reset, active-low
cu_active_o  out  NUM_CHANNELS  channel in RUN
l2_clk_en_o  out  1  L2 clock-gate enable
l2_rst_n_o  out  1  L2 reset, active-low
all_off_o  out  1  all channels OFF and L2 OFF

Behaviour:
- One clock (clk_i). Synchronous active-high reset (rst_i).
- All outputs are decoded from state registers only. There is no combinational input-to-output path.
- On reset, every channel is OFF and L2 is L2_OFF. All outputs are 0 except all_off_o=1. Counters are 0.
- Reset asserted mid-sequence aborts any state immediately, on the next edge.

Per-channel FSM (state: clk_en/rst_n/active):
- OFF (0/0/0):
  - start_i=1 and L2 in L2_ON -> RESET.
  - start_i=1 and L2 in any other state -> WAIT_L2.
- WAIT_L2 (0/0/0):
  - Moves to RESET on the first cycle L2 state is L2_ON. start_i may deassert meanwhile.
- RESET (1/0/0):
  - Counter counts RST_CYCLES cycles, then -> RUN.
  - Exactly RST_CYCLES cycles with clk_en=1, rst_n=0.
- RUN (1/1/1):
  - sleep_req_i=1 -> DRAIN, counter cleared.
  - start_i is ignored. If sleep_req_i and start_i are both asserted, sleep wins.
- DRAIN (1/1/0):
  - start_i=1 -> RUN (cancel). Cancel has priority over completion.
  - delay_sleep_i=1 -> counter cleared.
  - Otherwise the counter increments. When counter==DRAIN_CYCLES-1 with delay_sleep_i=0 -> OFF.
  - Minimum DRAIN residency is DRAIN_CYCLES cycles.
- Counter width is $clog2(max(RST_CYCLES,DRAIN_CYCLES))+1 and saturates; it never wraps.

L2 FSM (state: clk_en/rst_n):
- L2_OFF (0/0): any channel in WAIT_L2 -> L2_RESET.
- L2_RESET (1/0): held for RST_CYCLES cycles -> L2_ON.
- L2_ON (1/1): all channels OFF and l2_busy_i=0 -> L2_COOL, counter cleared.
- L2_COOL (1/1):
  - Any channel not OFF, or l2_busy_i=1 -> L2_ON.
  - Otherwise the counter increments. At L2_IDLE_CYCLES-1 -> L2_OFF.
  - Channels that see start_i during L2_COOL go to WAIT_L2. This forces L2_ON the next cycle, so they reach RESET one cycle later.
- all_off_o = (all channels OFF) & (L2 state L2_OFF).

Timing, start with L2 on:
- start_i at edge t -> RESET from t+1 to t+RST_CYCLES -> RUN at t+RST_CYCLES+1.

Timing, start from cold:
- start at t -> WAIT_L2 at t+1.
- L2_RESET from t+2 to t+1+RST_CYCLES.
- L2_ON at t+2+RST_CYCLES.
- Channel RESET at t+3+RST_CYCLES.

Test Plan:
- Cold start, defaults: start_i=4'b0001 one cycle -> l2_clk_en_o rises at t+2, l2_rst_n_o at t+4, cu_clk_en_o[0] at t+5, cu_rst_n_o[0] at t+7, cu_active_o[0] at t+7. Other channels stay 0.
- Drain restart: ch0 RUN, sleep_req_i[0] pulse, delay_sleep_i[0] high on cycles 2-3 of DRAIN -> cu_clk_en_o[0] falls exactly 4 quiet cycles after delay drops, not earlier.
- Cancel: ch0 in DRAIN cycle 3, start_i[0]=1 on the same cycle the count would complete -> returns to RUN. cu_active_o[0]=1 next cycle, clock never gated.
- L2 cool-down: last channel goes OFF, l2_busy_i=0 -> l2_clk_en_o drops after 8 cycles. Repeat with l2_busy_i pulsed at cool cycle 5 -> timer restarts from 0 and drops 8 cycles after busy clears.
- Multi-channel: ch1 and ch3 start together from cold -> both enter RESET on the same cycle. Sleeping ch1 alone keeps L2 on, and all_off_o=0.
- Reset mid-RESET and mid-DRAIN: rst_i=1 one cycle -> next cycle all outputs 0 and all_off_o=1.
